// File: rtl/booth_pkg.sv
// Shared types and helpers for the radix-4 Booth multiplier:
// FSM state encoding, recoded-operation enum and the iteration-count function.
package booth_pkg;

  localparam int TRIP_W = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_ZERO = 3'd0,
    OP_PM   = 3'd1,
    OP_P2M  = 3'd2,
    OP_MM   = 3'd3,
    OP_M2M  = 3'd4
  } op_t;

  // Two multiplier bits per iteration, plus one extra recode to consume the
  // two extension bits so unsigned operands come out exact.
  function automatic int calc_n_iter(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_r4_recoder.sv
// Modified-Booth recoder: maps the scanned triplet {Q[1],Q[0],q_1} to the
// operation to add into the accumulator, plus negate/double select lines.
module booth_r4_recoder
  import booth_pkg::*;
(
  input  logic [TRIP_W-1:0] i_trip,
  output op_t               o_op,
  output logic              o_neg,
  output logic              o_dbl
);

  // Triplet decode table.
  always_comb begin
    o_op = OP_ZERO;
    case (i_trip)
      3'b001, 3'b010: o_op = OP_PM;
      3'b011:         o_op = OP_P2M;
      3'b100:         o_op = OP_M2M;
      3'b101, 3'b110: o_op = OP_MM;
      default:        o_op = OP_ZERO;
    endcase
  end

  assign o_neg = (o_op == OP_MM) || (o_op == OP_M2M);
  assign o_dbl = (o_op == OP_P2M) || (o_op == OP_M2M);

endmodule

// File: rtl/booth_radix4_mult.sv
// Radix-4 (modified Booth) sequential multiplier with bgn/stop handshake.
// Signed or unsigned operands, 2*WIDTH registered product.
// WIDTH must be even and >= 4.
// Optional feature macro: BOOTH_R4_ZERO_SKIP_EN (zero operand -> IDLE->DONE,
// one-edge latency, product 0).
//
// state | meaning
// IDLE  | waiting for bgn; operands and mode are captured on the bgn edge
// ITER  | one recode + add + 2-bit arithmetic shift per edge, N_ITER edges
// DONE  | first edge: load obus and raise stop; second edge: drop stop/busy
module booth_radix4_mult
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 bgn,
  input  logic                 uns,
  input  logic [WIDTH-1:0]     ibusa,
  input  logic [WIDTH-1:0]     ibusb,
  output logic                 busy,
  output logic                 stop,
  output logic [2*WIDTH-1:0]   obus
);

  localparam int N_ITER = calc_n_iter(WIDTH);
  localparam int XW     = WIDTH + 2;
  localparam int CW     = $clog2(N_ITER + 1);

  state_t          r_state;
  logic [XW-1:0]   r_a;
  logic [XW-1:0]   r_q;
  logic [XW-1:0]   r_m;
  logic            r_q1;
  logic [CW-1:0]   r_cnt;

  op_t             w_op;
  logic            w_neg;
  logic            w_dbl;
  logic [XW-1:0]   w_a_ext;
  logic [XW-1:0]   w_b_ext;
  logic [XW-1:0]   w_mx;
  logic [XW-1:0]   w_addend;
  logic [XW-1:0]   w_sum;

  booth_r4_recoder u_recoder (
    .i_trip ({r_q[1], r_q[0], r_q1}),
    .o_op   (w_op),
    .o_neg  (w_neg),
    .o_dbl  (w_dbl)
  );

  // Operand extension: sign bits in signed mode, zeros in unsigned mode.
  assign w_a_ext = {{2{~uns & ibusa[WIDTH-1]}}, ibusa};
  assign w_b_ext = {{2{~uns & ibusb[WIDTH-1]}}, ibusb};

  // Adder input: +/-M or +/-2M; subtraction as inverted operand plus carry-in.
  // The partial sum always stays within [-2M, 2M), so XW bits never overflow.
  assign w_mx     = w_dbl ? {r_m[XW-2:0], 1'b0} : r_m;
  assign w_addend = (w_op == OP_ZERO) ? '0 : (w_neg ? ~w_mx : w_mx);
  assign w_sum    = r_a + w_addend + {{(XW-1){1'b0}}, w_neg};

  // Control FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_q     <= '0;
      r_m     <= '0;
      r_q1    <= 1'b0;
      r_cnt   <= '0;
      busy    <= 1'b0;
      stop    <= 1'b0;
      obus    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          stop <= 1'b0;
          if (bgn) begin
            r_m   <= w_b_ext;
            r_q   <= w_a_ext;
            r_a   <= '0;
            r_q1  <= 1'b0;
            r_cnt <= '0;
            busy  <= 1'b1;
`ifdef BOOTH_R4_ZERO_SKIP_EN
            // Q is cleared too so {A,Q} already holds the zero product.
            if ((w_a_ext == '0) || (w_b_ext == '0)) begin
              r_q     <= '0;
              r_state <= DONE;
            end else begin
              r_state <= ITER;
            end
`else
            r_state <= ITER;
`endif
          end
        end
        ITER: begin
          r_a   <= {{2{w_sum[XW-1]}}, w_sum[XW-1:2]};
          r_q   <= {w_sum[1:0], r_q[XW-1:2]};
          r_q1  <= r_q[1];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(N_ITER - 1)) begin
            r_state <= DONE;
          end
        end
        DONE: begin
          if (!stop) begin
            obus <= {r_a[WIDTH-3:0], r_q};
            stop <= 1'b1;
          end else begin
            stop    <= 1'b0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule
